instruction_fetch_unit: RTL and testbench

Front end of the MIPS pipeline, directly upstream of the program memory.
- Holds the PC and drives the program memory address.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Captures the returned instruction into the IF/ID pipeline register with stall, flush and valid handling.
- Counts retired fetches for performance/debug.

---
 rtl/instruction_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : MIPS fetch stage. Holds the PC, drives the program memory
//               address, chooses the next PC (JR > J > branch > PC+4) and
//               captures the returned word into the IF/ID register. Stall,
//               flush and valid are handled here, and retired fetches are
//               counted.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter int          DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  BranchTaken,
   input  logic [31:0]           BranchTarget,
   input  logic                  Jump,
   input  logic [25:0]           JumpIndex,
   input  logic                  JumpReg,
   input  logic [31:0]           JumpRegTarget,
   input  logic [DATA_WIDTH-1:0] InstructionIn,
   output logic [DATA_WIDTH-1:0] PCAddress,
   output logic [DATA_WIDTH-1:0] IF_ID_Instruction,
   output logic [DATA_WIDTH-1:0] IF_ID_PCPlus4,
   output logic                  IF_ID_Valid,
   output logic                  AddressError,
   output logic [31:0]           FetchCount
);

   localparam logic [DATA_WIDTH-1:0] c_PC_STEP = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] c_NOP     = '0;

   // Architectural state
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_ifid_instr;
   logic [DATA_WIDTH-1:0] r_ifid_pcplus4;
   logic                  r_ifid_valid;
   logic                  r_addr_err;
   logic [31:0]           r_fetch_count;

   // Next-state decode
   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic                  w_redirect;
   logic [DATA_WIDTH-1:0] w_target;
   logic [DATA_WIDTH-1:0] w_pc_next;
   logic                  w_bubble;
   logic                  w_load;
   logic                  w_jr_misaligned;

   assign w_pc_plus4      = r_pc + c_PC_STEP;
   assign w_redirect      = JumpReg | Jump | BranchTaken;
   assign w_jr_misaligned = JumpReg & (JumpRegTarget[1:0] != 2'b00);
   // Any redirect squashes the word fetched this cycle, as does Flush.
   assign w_bubble        = w_redirect | Flush;
   // A real instruction enters IF/ID only on an undisturbed cycle.
   assign w_load          = ~w_bubble & ~Stall;

   // Redirect target selection, JR highest priority, low two bits forced to 0
   always_comb begin
      w_target = w_pc_plus4;
      if (JumpReg) begin
         w_target = {JumpRegTarget[31:2], 2'b00};
      end else if (Jump) begin
         // Region bits come from the delay-slot address held in IF/ID.
         w_target = {r_ifid_pcplus4[31:28], JumpIndex, 2'b00};
      end else if (BranchTaken) begin
         w_target = {BranchTarget[31:2], 2'b00};
      end
   end

   // Next PC: redirect wins over Stall, otherwise Stall holds, else step
   always_comb begin
      w_pc_next = r_pc;
      if (w_redirect) begin
         w_pc_next = w_target;
      end else if (!Stall) begin
         w_pc_next = w_pc_plus4;
      end
   end

   // PC register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   // IF/ID pipeline register: bubble, hold on stall, or capture fetched word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ifid_instr   <= c_NOP;
         r_ifid_pcplus4 <= '0;
         r_ifid_valid   <= 1'b0;
      end else if (w_bubble) begin
         r_ifid_instr   <= c_NOP;
         r_ifid_pcplus4 <= '0;
         r_ifid_valid   <= 1'b0;
      end else if (w_load) begin
         r_ifid_instr   <= InstructionIn;
         r_ifid_pcplus4 <= w_pc_plus4;
         r_ifid_valid   <= 1'b1;
      end
   end

   // Sticky misaligned-JR flag, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr_err <= 1'b0;
      end else if (w_jr_misaligned) begin
         r_addr_err <= 1'b1;
      end
   end

   // Retired-fetch counter, wraps naturally at 2^32
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_count <= '0;
      end else if (w_load) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign PCAddress         = r_pc;
   assign IF_ID_Instruction = r_ifid_instr;
   assign IF_ID_PCPlus4     = r_ifid_pcplus4;
   assign IF_ID_Valid       = r_ifid_valid;
   assign AddressError      = r_addr_err;
   assign FetchCount        = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed bench for instruction_fetch_unit. Program memory is
//               modelled as word = address XOR a fixed key.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

   localparam logic [31:0] c_KEY = 32'hA5C3_0000;

   logic        clk;
   logic        reset;
   logic        Stall;
   logic        Flush;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [25:0] JumpIndex;
   logic        JumpReg;
   logic [31:0] JumpRegTarget;
   logic [31:0] InstructionIn;
   logic [31:0] PCAddress;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic        AddressError;
   logic [31:0] FetchCount;

   int total;
   int bad;

   instruction_fetch_unit dut (
      .clk               (clk),
      .reset             (reset),
      .Stall             (Stall),
      .Flush             (Flush),
      .BranchTaken       (BranchTaken),
      .BranchTarget      (BranchTarget),
      .Jump              (Jump),
      .JumpIndex         (JumpIndex),
      .JumpReg           (JumpReg),
      .JumpRegTarget     (JumpRegTarget),
      .InstructionIn     (InstructionIn),
      .PCAddress         (PCAddress),
      .IF_ID_Instruction (IF_ID_Instruction),
      .IF_ID_PCPlus4     (IF_ID_PCPlus4),
      .IF_ID_Valid       (IF_ID_Valid),
      .AddressError      (AddressError),
      .FetchCount        (FetchCount)
   );

   // Combinational program memory
   assign InstructionIn = PCAddress ^ c_KEY;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0; JumpReg = 0;
   endtask

   task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] pc4, input logic v, input logic [31:0] cnt);
      chk({tag, ".pc"},    PCAddress,         pc);
      chk({tag, ".instr"}, IF_ID_Instruction, ins);
      chk({tag, ".pc4"},   IF_ID_PCPlus4,     pc4);
      chk({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, v});
      chk({tag, ".count"}, FetchCount,        cnt);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      clear_ctl();
      BranchTarget  = 32'h0;
      JumpIndex     = 26'h0;
      JumpRegTarget = 32'h0;

      // Reset state (t=12, between edges)
      #12;
      chk_state("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
      chk("reset.aerr", {31'd0, AddressError}, 32'd0);
      reset = 1'b1;

      // Sequential fetch from RESET_PC
      step();
      chk_state("seq1", 32'h0040_0004, 32'h0040_0000 ^ c_KEY, 32'h0040_0004, 1'b1, 32'd1);
      step();
      chk_state("seq2", 32'h0040_0008, 32'h0040_0004 ^ c_KEY, 32'h0040_0008, 1'b1, 32'd2);

      // Stall three cycles at 0x00400008
      Stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_state("stall", 32'h0040_0008, 32'h0040_0004 ^ c_KEY, 32'h0040_0008, 1'b1, 32'd2);
      end
      Stall = 0;
      step();
      chk_state("unstall", 32'h0040_000C, 32'h0040_0008 ^ c_KEY, 32'h0040_000C, 1'b1, 32'd3);
      step();
      chk_state("seq5", 32'h0040_0010, 32'h0040_000C ^ c_KEY, 32'h0040_0010, 1'b1, 32'd4);

      // Jump with IF_ID_PCPlus4 = 0x00400010
      Jump = 1; JumpIndex = 26'h010_0010;
      step();
      clear_ctl();
      chk_state("jump", 32'h0040_0040, 32'h0, 32'h0, 1'b0, 32'd4);
      step();
      chk_state("postjump", 32'h0040_0044, 32'h0040_0040 ^ c_KEY, 32'h0040_0044, 1'b1, 32'd5);

      // Jump and JumpReg together: JR wins
      Jump = 1; JumpIndex = 26'h010_0010; JumpReg = 1; JumpRegTarget = 32'h0040_0080;
      step();
      clear_ctl();
      chk_state("jr_wins", 32'h0040_0080, 32'h0, 32'h0, 1'b0, 32'd5);
      chk("jr_wins.aerr", {31'd0, AddressError}, 32'd0);

      // Branch under Stall: redirect overrides stall
      BranchTaken = 1; BranchTarget = 32'h0040_0040; Stall = 1;
      step();
      clear_ctl();
      chk_state("br_stall", 32'h0040_0040, 32'h0, 32'h0, 1'b0, 32'd5);

      // Flush alone: bubble, PC advances
      Flush = 1;
      step();
      chk_state("flush", 32'h0040_0044, 32'h0, 32'h0, 1'b0, 32'd5);
      // Flush with Stall: bubble, PC holds
      Stall = 1;
      step();
      clear_ctl();
      chk_state("flush_stall", 32'h0040_0044, 32'h0, 32'h0, 1'b0, 32'd5);
      step();
      chk_state("refill", 32'h0040_0048, 32'h0040_0044 ^ c_KEY, 32'h0040_0048, 1'b1, 32'd6);

      // Misaligned JR: aligned target, sticky error
      JumpReg = 1; JumpRegTarget = 32'h0040_0022;
      step();
      clear_ctl();
      chk_state("jr_mis", 32'h0040_0020, 32'h0, 32'h0, 1'b0, 32'd6);
      chk("jr_mis.aerr", {31'd0, AddressError}, 32'd1);
      step();
      step();
      chk_state("after_mis", 32'h0040_0028, 32'h0040_0024 ^ c_KEY, 32'h0040_0028, 1'b1, 32'd8);
      chk("sticky.aerr", {31'd0, AddressError}, 32'd1);

      // Branch target low bits dropped; no AddressError change from branches
      BranchTaken = 1; BranchTarget = 32'h0040_0043;
      step();
      clear_ctl();
      chk("br_align.pc", PCAddress, 32'h0040_0040);
      for (int i = 0; i < 4; i++) step();
      chk_state("pre_rst", 32'h0040_0050, 32'h0040_004C ^ c_KEY, 32'h0040_0050, 1'b1, 32'd12);
      chk("pre_rst.aerr", {31'd0, AddressError}, 32'd1);

      // Asynchronous reset between edges
      #2;
      reset = 1'b0;
      #1;
      chk_state("async_rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
      chk("async_rst.aerr", {31'd0, AddressError}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // PC wrap at 2^32
      BranchTaken = 1; BranchTarget = 32'hFFFF_FFFC;
      step();
      clear_ctl();
      chk_state("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd0);
      step();
      chk_state("wrap", 32'h0000_0000, 32'hFFFF_FFFC ^ c_KEY, 32'h0000_0000, 1'b1, 32'd1);

      // Jump region bits come from IF_ID_PCPlus4
      BranchTaken = 1; BranchTarget = 32'h3000_0000;
      step();
      clear_ctl();
      step();
      chk("region.pc4", IF_ID_PCPlus4, 32'h3000_0004);
      Jump = 1; JumpIndex = 26'h000_0100;
      step();
      clear_ctl();
      chk("region.jump", PCAddress, 32'h3000_0400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
